// File: rtl/bv4_inv_pipe.sv
// Two-stage GF(2^4) inverter in tower normal basis, LANES independent nibbles per beat.
// Define BV4_INV_PIPE_CNT_EN to add a saturating out_count of output transfers.
module bv4_inv_pipe #(
    parameter int unsigned LANES = 1
) (
    input  logic               in_clock,
    input  logic               in_reset_n,
    input  logic [4*LANES-1:0] in_a,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*LANES-1:0] out_b,
    output logic               out_valid,
    input  logic               out_ready
`ifdef BV4_INV_PIPE_CNT_EN
    ,
    output logic [7:0]         out_count
`endif
);

    function automatic logic [1:0] gf2_swap(input logic [1:0] x);
        return {x[0], x[1]};
    endfunction

    function automatic logic [1:0] gf2_sigma(input logic [1:0] x);
        return {x[0], x[0] ^ x[1]};
    endfunction

    function automatic logic [1:0] gf2_mul(input logic [1:0] a, input logic [1:0] b);
        logic p;
        p = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ p, (a[0] & b[0]) ^ p};
    endfunction

    logic [2*LANES-1:0] theta_d, theta_q;
    logic [2*LANES-1:0] ah_d, ah_q;
    logic [2*LANES-1:0] al_d, al_q;
    logic [4*LANES-1:0] b_d, b_q;
    logic               v1_d, v1_q;
    logic               v2_d, v2_q;
    logic               load2, in_xfer, out_xfer;

    assign load2     = v1_q && (!v2_q || out_ready);
    assign in_ready  = !v1_q || load2;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = v2_q && out_ready;
    assign out_valid = v2_q;
    assign out_b     = b_q;

    always_comb begin
        theta_d = '0;
        ah_d    = '0;
        al_d    = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            ah_d[2*i +: 2]    = in_a[4*i+2 +: 2];
            al_d[2*i +: 2]    = in_a[4*i +: 2];
            theta_d[2*i +: 2] = gf2_sigma(gf2_swap(ah_d[2*i +: 2] ^ al_d[2*i +: 2]))
                              ^ gf2_mul(ah_d[2*i +: 2], al_d[2*i +: 2]);
        end
    end

    // theta == 0 only for a zero operand, and its swap-inverse 0 yields a zero result.
    always_comb begin
        b_d = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            b_d[4*i+2 +: 2] = gf2_mul(gf2_swap(theta_q[2*i +: 2]), al_q[2*i +: 2]);
            b_d[4*i +: 2]   = gf2_mul(gf2_swap(theta_q[2*i +: 2]), ah_q[2*i +: 2]);
        end
    end

    always_comb begin
        v1_d = v1_q;
        if (in_xfer) begin
            v1_d = 1'b1;
        end else if (load2) begin
            v1_d = 1'b0;
        end
        v2_d = v2_q;
        if (load2) begin
            v2_d = 1'b1;
        end else if (out_xfer) begin
            v2_d = 1'b0;
        end
    end

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            theta_q <= '0;
            ah_q    <= '0;
            al_q    <= '0;
            v1_q    <= 1'b0;
            b_q     <= '0;
            v2_q    <= 1'b0;
        end else begin
            if (in_xfer) begin
                theta_q <= theta_d;
                ah_q    <= ah_d;
                al_q    <= al_d;
            end
            if (load2) begin
                b_q <= b_d;
            end
            v1_q <= v1_d;
            v2_q <= v2_d;
        end
    end

`ifdef BV4_INV_PIPE_CNT_EN
    logic [7:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (out_xfer && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_count = cnt_q;
`endif

endmodule

// File: tb/tb_bv4_inv_pipe.sv
// Directed bench for bv4_inv_pipe: identity/zero, involution sweep, backpressure, reset, lanes.
module tb_bv4_inv_pipe;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_a;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] in_a2;
    logic       in_valid2;
    logic       in_ready2;
    logic [7:0] out_b2;
    logic       out_valid2;
    logic       out_ready2;
`ifdef BV4_INV_PIPE_CNT_EN
    logic [7:0] out_count;
    logic [7:0] out_count2;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Hand-computed inverse table in the tower normal basis.
    logic [3:0] inv_tbl [16] = '{4'h0, 4'hC, 4'h8, 4'h4, 4'h3, 4'hA, 4'h7, 4'h6,
                                 4'h2, 4'hD, 4'h5, 4'hE, 4'h1, 4'h9, 4'hB, 4'hF};
    logic [3:0] res [16];

    bv4_inv_pipe #(.LANES(1)) u_dut (
        .in_clock   (clk),
        .in_reset_n (rst_n),
        .in_a       (in_a),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_b      (out_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef BV4_INV_PIPE_CNT_EN
        ,
        .out_count  (out_count)
`endif
    );

    bv4_inv_pipe #(.LANES(2)) u_dut2 (
        .in_clock   (clk),
        .in_reset_n (rst_n),
        .in_a       (in_a2),
        .in_valid   (in_valid2),
        .in_ready   (in_ready2),
        .out_b      (out_b2),
        .out_valid  (out_valid2),
        .out_ready  (out_ready2)
`ifdef BV4_INV_PIPE_CNT_EN
        ,
        .out_count  (out_count2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_a       = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        in_a2      = '0;
        in_valid2  = 1'b0;
        out_ready2 = 1'b1;
        #3;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_out_b", {28'd0, out_b}, 32'd0);
        #20 rst_n = 1'b1;
        tick();

        // Identity and zero with exact two-cycle latency.
        in_a = 4'hF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("id_lat1", {31'd0, out_valid}, 32'd0);
        tick();
        check_eq("id_valid", {31'd0, out_valid}, 32'd1);
        check_eq("id_b", {28'd0, out_b}, 32'hF);
        in_a = 4'h0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("zero_lat1", {31'd0, out_valid}, 32'd0);
        tick();
        check_eq("zero_valid", {31'd0, out_valid}, 32'd1);
        check_eq("zero_b", {28'd0, out_b}, 32'h0);

        // Involution sweep: forward pass then feed results back.
        for (int i = 0; i <= 16; i++) begin
            in_valid = (i < 16);
            in_a     = i[3:0];
            tick();
            if (i >= 1) begin
                check_eq("sweep_valid", {31'd0, out_valid}, 32'd1);
                check_eq("sweep_b", {28'd0, out_b}, {28'd0, inv_tbl[i-1]});
                res[i-1] = out_b;
            end
        end
        for (int i = 0; i <= 16; i++) begin
            in_valid = (i < 16);
            in_a     = (i < 16) ? res[i] : 4'h0;
            tick();
            if (i >= 1) begin
                check_eq("back_valid", {31'd0, out_valid}, 32'd1);
                check_eq("back_b", {28'd0, out_b}, i - 1);
            end
        end
        in_valid = 1'b0;
        tick();
        check_eq("drain_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: two accepts, then stall with the first result held.
        out_ready = 1'b0; in_valid = 1'b1; in_a = 4'h1;
        #1 check_eq("bp_rdy0", {31'd0, in_ready}, 32'd1);
        tick();
        in_a = 4'h2;
        #1 check_eq("bp_rdy1", {31'd0, in_ready}, 32'd1);
        tick();
        in_a = 4'h3;
        #1 check_eq("bp_full", {31'd0, in_ready}, 32'd0);
        check_eq("bp_b0", {28'd0, out_b}, 32'hC);
        tick();
        tick();
        check_eq("bp_hold_v", {31'd0, out_valid}, 32'd1);
        check_eq("bp_hold_b", {28'd0, out_b}, 32'hC);
        check_eq("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1 check_eq("bp_pass_rdy", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check_eq("bp_b1", {28'd0, out_b}, 32'h8);
        check_eq("bp_v1", {31'd0, out_valid}, 32'd1);
        tick();
        check_eq("bp_b2", {28'd0, out_b}, 32'h4);
        check_eq("bp_v2", {31'd0, out_valid}, 32'd1);
        tick();
        check_eq("bp_empty", {31'd0, out_valid}, 32'd0);

        // Reset with both stages occupied.
        out_ready = 1'b0; in_valid = 1'b1; in_a = 4'h5;
        tick();
        in_a = 4'h6;
        tick();
        in_valid = 1'b0;
        check_eq("mid_full_v", {31'd0, out_valid}, 32'd1);
        check_eq("mid_full_b", {28'd0, out_b}, 32'hA);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_v", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
        check_eq("mid_rst_b", {28'd0, out_b}, 32'h0);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        check_eq("post_rst_stale", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b1; in_a = 4'h9;
        tick();
        in_valid = 1'b0;
        tick();
        check_eq("post_rst_v", {31'd0, out_valid}, 32'd1);
        check_eq("post_rst_b", {28'd0, out_b}, 32'hD);

        // in_a ignored while in_valid is low.
        in_a = 4'hF;
        tick();
        tick();
        check_eq("ignore_v", {31'd0, out_valid}, 32'd0);

        // Two lanes processed independently.
        in_valid2 = 1'b1; in_a2 = 8'hF0;
        tick();
        in_a2 = 8'h1C;
        tick();
        check_eq("lane2_v0", {31'd0, out_valid2}, 32'd1);
        check_eq("lane2_b0", {24'd0, out_b2}, 32'hF0);
        in_valid2 = 1'b0;
        tick();
        check_eq("lane2_b1", {24'd0, out_b2}, 32'hC1);

`ifdef BV4_INV_PIPE_CNT_EN
        in_valid = 1'b1; in_a = 4'h3;
        for (int i = 0; i < 300; i++) tick();
        in_valid = 1'b0;
        tick();
        tick();
        check_eq("cnt_sat", {24'd0, out_count}, 32'd255);
        rst_n = 1'b0;
        #1 check_eq("cnt_rst", {24'd0, out_count}, 32'd0);
        rst_n = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
